// File: rtl/fetch_stall_regs.sv
// fetch_stall_regs: PC, IF/ID and ID/EX-control registers obeying stall/flush; FETCH_PERF_CNT_EN adds stall/flush counters
module fetch_stall_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 9,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       flush_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_pc4,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic [31:0]       pc_q, pc_d, if_id_pc4_q, if_id_pc4_d, if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [31:0]       pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;
  // next state: flush overrides everything, otherwise each register follows its own enable
  always_comb begin
    pc_d          = flush ? flush_target : pc_write ? pc_plus4 : pc_q;
    if_id_pc4_d   = flush ? 32'd0 : if_id_write ? pc_plus4 : if_id_pc4_q;
    if_id_instr_d = flush ? 32'd0 : if_id_write ? imem_instr : if_id_instr_q;
    if_id_valid_d = flush ? 1'b0 : if_id_write ? 1'b1 : if_id_valid_q;
    ex_ctrl_d     = (flush || stall || !if_id_valid_q) ? '0 : id_ctrl;
  end
  // pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
      ex_ctrl_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end
  assign pc          = pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // saturating counters: stall counts only when not overridden by flush
  always_comb begin
    stall_cnt_d = (!flush && stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  // counter registers, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_stall_regs.sv
// tb_fetch_stall_regs: directed plus random stimulus against a per-field reference model of fetch_stall_regs
module tb_fetch_stall_regs;
  localparam int CW = 9;
  localparam int NW = 6;
  localparam logic [NW-1:0] CMAX = '1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic pc_write = 1'b0, if_id_write = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] flush_target = '0, imem_instr = '0;
  logic [CW-1:0] id_ctrl = '0;
  logic [31:0] pc, if_id_pc4, if_id_instr;
  logic if_id_valid;
  logic [CW-1:0] ex_ctrl;
  logic [NW-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_pc4, m_instr;
  logic m_valid;
  logic [CW-1:0] m_ctrl;
  logic [NW-1:0] m_scnt, m_fcnt;

  fetch_stall_regs #(.RESET_PC(32'h0), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
    .stall(stall), .flush(flush), .flush_target(flush_target), .imem_instr(imem_instr),
    .id_ctrl(id_ctrl), .pc(pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = '0; m_instr = '0; m_valid = 1'b0; m_ctrl = '0; m_scnt = '0; m_fcnt = '0;
  endtask

  task automatic check(input string tag);
    checks++; assert (pc === m_pc) else begin errors++; $error("FAIL %s pc got %h exp %h", tag, pc, m_pc); end
    checks++; assert (if_id_pc4 === m_pc4) else begin errors++; $error("FAIL %s if_id_pc4 got %h exp %h", tag, if_id_pc4, m_pc4); end
    checks++; assert (if_id_instr === m_instr) else begin errors++; $error("FAIL %s if_id_instr got %h exp %h", tag, if_id_instr, m_instr); end
    checks++; assert (if_id_valid === m_valid) else begin errors++; $error("FAIL %s if_id_valid got %b exp %b", tag, if_id_valid, m_valid); end
    checks++; assert (ex_ctrl === m_ctrl) else begin errors++; $error("FAIL %s ex_ctrl got %h exp %h", tag, ex_ctrl, m_ctrl); end
    checks++; assert (stall_cnt === m_scnt) else begin errors++; $error("FAIL %s stall_cnt got %0d exp %0d", tag, stall_cnt, m_scnt); end
    checks++; assert (flush_cnt === m_fcnt) else begin errors++; $error("FAIL %s flush_cnt got %0d exp %0d", tag, flush_cnt, m_fcnt); end
  endtask

  task automatic step(input string tag, input logic f, input logic s, input logic pw, input logic iw, input logic [31:0] tgt);
    logic [31:0] n_pc, n_pc4, n_instr;
    logic n_valid;
    logic [CW-1:0] n_ctrl;
    logic [NW-1:0] n_scnt, n_fcnt;
    @(negedge clk);
    flush = f; stall = s; pc_write = pw; if_id_write = iw; flush_target = tgt;
    imem_instr = $urandom; id_ctrl = CW'($urandom);
    n_pc = m_pc; n_pc4 = m_pc4; n_instr = m_instr; n_valid = m_valid; n_scnt = m_scnt; n_fcnt = m_fcnt;
    if (f) begin
      n_pc = tgt; n_pc4 = 0; n_instr = 0; n_valid = 0; n_ctrl = 0;
`ifdef FETCH_PERF_CNT_EN
      if (m_fcnt != CMAX) n_fcnt = m_fcnt + 1;
`endif
    end else begin
      if (pw) n_pc = m_pc + 32'd4;
      if (iw) begin n_pc4 = m_pc + 32'd4; n_instr = imem_instr; n_valid = 1; end
      n_ctrl = (s || !m_valid) ? '0 : id_ctrl;
`ifdef FETCH_PERF_CNT_EN
      if (s && m_scnt != CMAX) n_scnt = m_scnt + 1;
`endif
    end
    @(posedge clk); #1;
    m_pc = n_pc; m_pc4 = n_pc4; m_instr = n_instr; m_valid = n_valid; m_ctrl = n_ctrl; m_scnt = n_scnt; m_fcnt = n_fcnt;
    check(tag);
  endtask

  initial begin
    model_reset();
    #3 check("reset");
    @(negedge clk); rst_n = 1'b1;
    check("reset_release");
    step("run1", 0, 0, 1, 1, 0);
    step("run2", 0, 0, 1, 1, 0);
    step("loaduse", 0, 1, 0, 0, 0);
    step("resume", 0, 0, 1, 1, 0);
    step("run3", 0, 0, 1, 1, 0);
    step("flush_stall", 1, 1, 0, 0, 32'h40);
    step("after_flush", 0, 0, 1, 1, 0);
    step("mixed_a", 0, 0, 0, 1, 0);
    step("mixed_b", 0, 1, 1, 0, 0);
    step("to_wrap", 1, 0, 1, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 1, 1, 0);
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, {$urandom} & 32'hFFFF_FFFC);
    step("pre_rst", 0, 0, 1, 1, 0);
    @(negedge clk);
    stall = 1; pc_write = 0; if_id_write = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1 model_reset(); check("async_rst");
    #1 rst_n = 1'b1;
    for (int i = 0; i < (1 << NW) + 5; i++) step("sat", 0, 1, 0, 0, 0);
    for (int i = 0; i < (1 << NW) + 5; i++) step("fsat", 1, 0, 1, 1, 32'h100);
    step("final", 0, 0, 1, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stall_regs.md
Name: fetch_stall_regs

Overview:
- Receiving end of the load-use stall handshake.
- Owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register.
- Obeys the pc_write, if_id_write and stall signals from the hazard detector, plus branch/jump flush from EX.
- Sits between instruction memory and the decode stage; inserts bubbles and redirects fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 9, width of the ID-stage control bundle carried into EX.
- CNT_W, 16, width of the performance counters (only used when the optional feature is enabled).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_write  in  1  1 = PC may advance; 0 = hold PC
- if_id_write  in  1  1 = IF/ID may load; 0 = hold IF/ID
- stall  in  1  1 = load a bubble (zero control) into ID/EX
- flush  in  1  taken branch/jump resolved in EX
- flush_target  in  32  redirect PC when flush=1
- imem_instr  in  32  instruction read at the current pc (combinational imem)
- id_ctrl  in  CTRL_W  decoded control bundle from ID
- pc  out  32  current fetch address
- if_id_pc4  out  32  registered PC+4 of the decoding instruction
- if_id_instr  out  32  registered instruction
- if_id_valid  out  1  1 = IF/ID holds a real instruction
- ex_ctrl  out  CTRL_W  registered control into EX
- stall_cnt  out  CNT_W  cycles with stall=1 (optional feature)
- flush_cnt  out  CNT_W  flush events (optional feature)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, if_id_pc4=0, if_id_instr=0, if_id_valid=0, ex_ctrl=0, stall_cnt=0, flush_cnt=0. Deassertion is sampled at the next rising edge; the first fetch is at RESET_PC.
- All updates occur on the rising edge of clk.
- Per-edge priority: flush > stall/hold > normal.
- flush=1:
  - pc <= flush_target
  - if_id_instr <= 0, if_id_valid <= 0, if_id_pc4 <= 0
  - ex_ctrl <= 0
  - pc_write, if_id_write and stall are ignored that cycle.
- flush=0, PC: pc_write=1 gives pc <= pc+32'd4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0). pc_write=0 holds pc.
- flush=0, IF/ID: if_id_write=1 gives if_id_pc4 <= pc+4, if_id_instr <= imem_instr, if_id_valid <= 1. if_id_write=0 holds all three.
- flush=0, ID/EX: stall=1 gives ex_ctrl <= 0 (bubble). stall=0 gives ex_ctrl <= id_ctrl, or 0 if if_id_valid=0 (no stray control from an empty slot).
- Independence: pc_write, if_id_write and stall are applied independently. Mixed combinations (e.g. pc_write=0 with if_id_write=1) are legal and follow the per-field rules above.
- Consecutive stalls: each stalled cycle holds pc and IF/ID and re-inserts a bubble; there is no limit.
- Latency: one cycle from input to every registered output; no combinational paths from inputs to outputs.
- Reset mid-stall or mid-flush: reset wins immediately and asynchronously; all state returns to reset values.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every edge with flush=0 and stall=1.
  - flush_cnt increments on every edge with flush=1.
  - Both counters saturate at all-ones (no wrap) and clear only on reset.
- Undefined: no counter flops are built; stall_cnt and flush_cnt are driven constant 0. All other behaviour is identical.

Test Plan:
- Reset then run 3 cycles with pc_write=if_id_write=1, stall=flush=0, RESET_PC=0 -> pc 0,4,8,12; if_id_pc4=12 with if_id_valid=1 after 3 edges.
- Load-use stall: at pc=8 drive pc_write=0, if_id_write=0, stall=1 for 1 cycle -> pc stays 8, IF/ID unchanged, ex_ctrl=0 for 1 cycle, then resumes to 12; stall_cnt=1 (feature on).
- Flush together with stall: flush=1, flush_target=32'h40, stall=1, pc_write=0 -> next pc=32'h40, if_id_valid=0, ex_ctrl=0; flush_cnt=1, stall_cnt unchanged.
- Wrap: force pc=32'hFFFF_FFFC via flush, then advance -> pc=0, if_id_pc4=0.
- Async reset pulse mid-cycle during a stall -> all outputs reset values before the next clk edge; feature on, drive stall for 2^CNT_W+5 cycles -> stall_cnt holds at all-ones.
- Build without FETCH_PERF_CNT_EN, repeat the stall test -> stall_cnt=flush_cnt=0 throughout; pc and IF/ID trace identical to the feature-on run.
